input_conditioner: RTL and testbench

Parametrised multi-channel input conditioner that generalises the single-bit button debounce used on the `clk_mac` domain. Per channel it provides:

- a metastability synchroniser;
- a counter-based debounce filter;
- registered rise and fall event pulses;
- an optional long-press event.

It sits between board pins (buttons, switches) and control logic such as MAC test and packet-trigger FSMs, replacing individual debounce instances with one block.

---
 rtl/input_cond_pkg.sv | 12 +
 rtl/input_cond_channel.sv | 99 +++++++++
 rtl/input_conditioner.sv | 40 ++++
 tb/tb_input_conditioner.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/input_cond_pkg.sv
// rtl/input_cond_pkg.sv - shared constants and width helper for input_conditioner
package input_cond_pkg;

  localparam int IC_SYNC_STAGES_DEF = 2;
  localparam int IC_DEBOUNCE_DEF    = 65536;

  // clog2 with a floor of 1 so single-value counters still get a bit
  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/input_cond_channel.sv
// rtl/input_cond_channel.sv - one channel: synchroniser, debounce, edge pulses, long press
// Long-press hold counter built only with INPUT_CONDITIONER_LONG_PRESS_EN.
module input_cond_channel
  import input_cond_pkg::*;
#(
  parameter int SYNC_STAGES     = IC_SYNC_STAGES_DEF,
  parameter int DEBOUNCE_CYCLES = IC_DEBOUNCE_DEF,
  parameter int LONG_CYCLES     = 50000000,
  parameter bit INIT            = 1'b0
) (
  input  logic clk_mac,
  input  logic rst_n,
  input  logic i_in,
  output logic o_out,
  output logic o_rise,
  output logic o_fall,
  output logic o_long_press
);

  localparam int DW = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [DW-1:0] D_LAST = DW'(DEBOUNCE_CYCLES - 1);

  if (SYNC_STAGES < 2)     begin : g_bad_sync  $error("SYNC_STAGES must be >= 2");     end
  if (DEBOUNCE_CYCLES < 1) begin : g_bad_deb   $error("DEBOUNCE_CYCLES must be >= 1"); end
  if (LONG_CYCLES < 1)     begin : g_bad_long  $error("LONG_CYCLES must be >= 1");     end

  logic [SYNC_STAGES-1:0] r_sync;
  logic [DW-1:0]          r_dcnt;
  logic                   r_out;
  logic                   r_rise;
  logic                   r_fall;
  logic                   w_s;

  assign w_s = r_sync[SYNC_STAGES-1];

  always_ff @(posedge clk_mac or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= {SYNC_STAGES{INIT}};
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_in};
    end
  end

  // Any sample agreeing with out restarts the count, rejecting short glitches
  always_ff @(posedge clk_mac or negedge rst_n) begin
    if (!rst_n) begin
      r_dcnt <= '0;
      r_out  <= INIT;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_rise <= 1'b0;
      r_fall <= 1'b0;
      if (w_s == r_out) begin
        r_dcnt <= '0;
      end else if (r_dcnt == D_LAST) begin
        r_dcnt <= '0;
        r_out  <= w_s;
        r_rise <= w_s;
        r_fall <= ~w_s;
      end else begin
        r_dcnt <= r_dcnt + 1'b1;
      end
    end
  end

  assign o_out  = r_out;
  assign o_rise = r_rise;
  assign o_fall = r_fall;

`ifdef INPUT_CONDITIONER_LONG_PRESS_EN
  localparam int HW = cnt_width(LONG_CYCLES + 1);
  localparam logic [HW-1:0] H_LAST = HW'(LONG_CYCLES);

  logic [HW-1:0] r_hcnt;
  logic          r_long;

  // Saturating at H_LAST makes the pulse fire once per hold
  always_ff @(posedge clk_mac or negedge rst_n) begin
    if (!rst_n) begin
      r_hcnt <= '0;
      r_long <= 1'b0;
    end else begin
      r_long <= 1'b0;
      if (!r_out) begin
        r_hcnt <= '0;
      end else if (r_hcnt != H_LAST) begin
        r_hcnt <= r_hcnt + 1'b1;
        r_long <= (r_hcnt == H_LAST - 1'b1);
      end
    end
  end

  assign o_long_press = r_long;
`else
  assign o_long_press = 1'b0;
`endif

endmodule

// File: rtl/input_conditioner.sv
// rtl/input_conditioner.sv - multi-channel debounce/edge/long-press conditioner
// Long-press logic built only with INPUT_CONDITIONER_LONG_PRESS_EN.
module input_conditioner
  import input_cond_pkg::*;
#(
  parameter int                  CHANNELS        = 4,
  parameter int                  SYNC_STAGES     = IC_SYNC_STAGES_DEF,
  parameter int                  DEBOUNCE_CYCLES = IC_DEBOUNCE_DEF,
  parameter int                  LONG_CYCLES     = 50000000,
  parameter logic [CHANNELS-1:0] INIT            = {CHANNELS{1'b0}}
) (
  input  logic                clk_mac,
  input  logic                rst_n,
  input  logic [CHANNELS-1:0] in,
  output logic [CHANNELS-1:0] out,
  output logic [CHANNELS-1:0] rise,
  output logic [CHANNELS-1:0] fall,
  output logic [CHANNELS-1:0] long_press
);

  if (CHANNELS < 1) begin : g_bad_ch $error("CHANNELS must be >= 1"); end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    input_cond_channel #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .LONG_CYCLES     (LONG_CYCLES),
      .INIT            (INIT[i])
    ) u_channel (
      .clk_mac      (clk_mac),
      .rst_n        (rst_n),
      .i_in         (in[i]),
      .o_out        (out[i]),
      .o_rise       (rise[i]),
      .o_fall       (fall[i]),
      .o_long_press (long_press[i])
    );
  end

endmodule

// File: tb/tb_input_conditioner.sv
// tb/tb_input_conditioner.sv - directed self-checking bench for input_conditioner
module tb_input_conditioner;

`ifdef INPUT_CONDITIONER_LONG_PRESS_EN
  localparam bit LP_EN = 1'b1;
`else
  localparam bit LP_EN = 1'b0;
`endif

  logic       clk_mac = 1'b0;
  logic       rst_n;
  logic [3:0] tb_in;
  logic [3:0] w_out, w_rise, w_fall, w_long;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk_mac = ~clk_mac;

  input_conditioner #(
    .CHANNELS        (4),
    .SYNC_STAGES     (2),
    .DEBOUNCE_CYCLES (8),
    .LONG_CYCLES     (20),
    .INIT            (4'b0000)
  ) dut (
    .clk_mac    (clk_mac),
    .rst_n      (rst_n),
    .in         (tb_in),
    .out        (w_out),
    .rise       (w_rise),
    .fall       (w_fall),
    .long_press (w_long)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_mac);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    tb_in = 4'b0000;
    step();
    step();
    check("rst_out", w_out, 4'b0000);
    check("rst_rise", w_rise, 4'b0000);
    check("rst_fall", w_fall, 4'b0000);
    check("rst_long", w_long, 4'b0000);
    rst_n = 1'b1;
    step();
    step();

    // clean step on channel 0: 10 edges counting the first sampling edge
    tb_in[0] = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      step();
      check("step_out", w_out[0], (i == 10));
      check("step_rise", w_rise[0], (i == 10));
      check("step_fall", w_fall, 4'b0000);
    end
    step();
    check("step_rise_clear", w_rise[0], 1'b0);

    // long press: 20 edges after the rise edge, then never again
    for (int i = 2; i <= 40; i++) begin
      step();
      check("long_pulse", w_long[0], LP_EN && (i == 20));
    end

    tb_in[0] = 1'b0;
    for (int i = 1; i <= 14; i++) begin
      step();
      check("rel_out", w_out[0], (i < 10));
      check("rel_fall", w_fall[0], (i == 10));
      check("rel_long", w_long[0], 1'b0);
    end

    // 7-cycle glitch on channel 1 is one sample short of acceptance
    tb_in[1] = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      if (i == 8) tb_in[1] = 1'b0;
      step();
      check("glitch_out", w_out[1], 1'b0);
      check("glitch_rise", w_rise[1], 1'b0);
      check("glitch_fall", w_fall[1], 1'b0);
    end

    // bounce on channel 2, then settle high
    for (int seg = 0; seg < 10; seg++) begin
      tb_in[2] = (seg % 2 == 0);
      for (int k = 0; k < 3; k++) begin
        step();
        check("bounce_out", w_out[2], 1'b0);
        check("bounce_rise", w_rise[2], 1'b0);
      end
    end
    tb_in[2] = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      step();
      check("bounce_settle_rise", w_rise[2], (i == 10));
      check("bounce_settle_out", w_out[2], (i >= 10));
    end

    // simultaneous rise on channel 3 and fall on channel 1
    tb_in[1] = 1'b1;
    for (int i = 1; i <= 12; i++) step();
    check("sim_pre_out1", w_out[1], 1'b1);
    tb_in[1] = 1'b0;
    tb_in[3] = 1'b1;
    for (int i = 1; i <= 11; i++) begin
      step();
      check("sim_rise3", w_rise[3], (i == 10));
      check("sim_fall1", w_fall[1], (i == 10));
    end

    // reset mid-count: channel 0 has dcnt=5 after 7 edges
    tb_in[0] = 1'b1;
    for (int i = 1; i <= 7; i++) step();
    check("pre_rst_out", w_out, 4'b1100);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_out", w_out, 4'b0000);
    check("async_rst_rise", w_rise, 4'b0000);
    check("async_rst_fall", w_fall, 4'b0000);
    check("async_rst_long", w_long, 4'b0000);
    #2;
    rst_n = 1'b1;
    for (int i = 1; i <= 11; i++) begin
      step();
      check("post_rst_out", w_out, (i >= 10) ? 4'b1101 : 4'b0000);
      check("post_rst_rise", w_rise, (i == 10) ? 4'b1101 : 4'b0000);
      check("post_rst_fall", w_fall, 4'b0000);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
